nes_cpu_bus_master: RTL and testbench
=====================================

# nes_cpu_bus_master

Drives the NES CPU-side cartridge bus (M2, /ROMSEL, R/W, A14..A0, D7..D0) from a simple command interface, acting as the initiator that MMC3-style mapper register files respond to. Also generates a PPU A12 scanline pulse train and samples the mapper's open-drain /IRQ. Sits in the bring-up/test harness in place of a real 6502 + PPU, so mapper banking and IRQ logic can be exercised from a soft controller.

## Interface
Parameters:
- M2_DIV, 6, clk cycles per M2 half-phase (M2 period = 2*M2_DIV clk); legal range 2..255
- A12_PERIOD, 114, M2 cycles between PPU A12 rising edges when the A12 generator is enabled; legal range 4..1023
- IDLE_ADDR, 16'h0000, address driven on idle bus cycles (must have bit 15 = 0)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write cycle, 0 = read cycle
- cmd_addr  in  16  CPU address $0000-$FFFF
- cmd_wdata  in  8  write data
- rsp_valid  out  1  one-clk pulse: read data available
- rsp_rdata  out  8  read data, held until next rsp_valid
- m2  out  1  CPU M2 clock
- romsel  out  1  /ROMSEL = ~(A15 & m2)
- cpu_rw  out  1  1 = read, 0 = write
- cpu_addr  out  15  A14..A0
- cpu_data_out  out  8  write data
- cpu_data_oe  out  1  data bus drive enable
- cpu_data_in  in  8  read data from cartridge
- a12_en  in  1  enable A12 pulse train
- ppu_a12  out  1  PPU A12
- irq_n  in  1  mapper /IRQ (asynchronous)
- irq_seen  out  1  sticky: /IRQ observed low
- irq_clr  in  1  clears irq_seen

## Operation
- M2 runs continuously after reset: LOW phase M2_DIV clk, HIGH phase M2_DIV clk; every M2 period is one bus cycle.
- Two-state FSM: LOW (m2=0), HIGH (m2=1); phase counter 0..M2_DIV-1 per state; LOW→HIGH and HIGH→LOW when counter = M2_DIV-1.
- cmd_ready=1 only on the last clk of HIGH. Accepted command becomes the next bus cycle; otherwise next cycle is idle: cpu_rw=1, address IDLE_ADDR.
- cpu_addr and cpu_rw change only at the LOW start and are stable for the full cycle; romsel combinational from latched A15 and m2.
- Write cycle: cpu_data_oe=1 and cpu_data_out valid for the whole HIGH phase; romsel/m2 fall together, so the mapper's write strobe (romsel rise for A15=1) lands with data still driven; oe drops on the first LOW clk of the next cycle.
- Read cycle: cpu_data_in sampled on the last HIGH clk; rsp_valid pulses on the next clk (first LOW clk of the following cycle) with rsp_rdata.
- A12 generator: M2-cycle counter 0..A12_PERIOD-1 while a12_en; ppu_a12=1 for exactly M2 cycle 0 (LOW start to LOW start), else 0. a12_en low → counter and ppu_a12 cleared at next cycle boundary. Low time between pulses is always ≥3 M2 rises.
- irq_n passed through a 2-flop synchronizer; synchronized low sets irq_seen; irq_clr clears it; set wins over simultaneous clear.

## Timing
- Reset values: m2=0, romsel=1, cpu_rw=1, cpu_addr=IDLE_ADDR[14:0], cpu_data_out=0, cpu_data_oe=0, cmd_ready=0, rsp_valid=0, rsp_rdata=0, ppu_a12=0, irq_seen=0, FSM=LOW, counters 0.
- First LOW phase begins on the first clk after rst_n release.
- Command latency: handshake clk → bus cycle starts next clk; read response 2*M2_DIV+1 clk after handshake.
- Throughput: one command per M2 period; back-to-back commands produce consecutive bus cycles with no idle gap.
- Reset asserted during HIGH of an A15=1 cycle forces romsel high early; mapper may latch that write. Documented, not prevented.
- irq_seen latency: 2-3 clk after irq_n falls.

## Structure
- Package nes_bus_pkg: FSM state enum, bus-cycle struct {write, addr[15:0], wdata[7:0]}, MMC3 register address constants ($8000, $8001, $A000, $A001, $C000, $C001, $E000, $E001).
- Sub-module m2_phase_gen: FSM + phase counter, outputs m2, cycle_start, cycle_last strobes; top holds bus-cycle register, read capture, A12 generator, IRQ sampler.

## Test plan (M2_DIV=2)
- Reset release, no commands -> m2 period 4 clk, romsel constantly 1, cpu_rw=1, cpu_addr=0, cmd_ready pulses once per 4 clk.
- Write $8000←$06 then $8001←$1F back-to-back -> two consecutive cycles, romsel low during each HIGH, oe=1 during HIGH, romsel rises at m2 fall with data stable.
- Read $FFFC with cpu_data_in=$A5 -> rsp_valid one clk, rsp_rdata=$A5, exactly 5 clk after handshake.
- Write $6000←$55 -> romsel stays 1, cpu_rw=0, cpu_addr=$6000.
- a12_en=1, A12_PERIOD=4 -> ppu_a12 high 4 clk every 16 clk; drop a12_en -> ppu_a12=0 from next cycle boundary.
- irq_n low 1 clk with irq_clr asserted same clk as set -> irq_seen=1; irq_clr later alone -> irq_seen=0.

Source files
------------

// File: rtl/nes_bus_pkg.sv
// Shared types and constants for the NES CPU-side bus master.
//   m2_state_t : M2 phase FSM state (LOW / HIGH)
//   bus_cyc_t  : one CPU bus cycle as latched at the cycle boundary
//   MMC3_*     : MMC3 register addresses (only A15, A14, A13 and A0 are decoded)
package nes_bus_pkg;

  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } m2_state_t;

  typedef struct packed {
    logic        write;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } bus_cyc_t;

  localparam logic [15:0] MMC3_BANK_SEL   = 16'h8000;
  localparam logic [15:0] MMC3_BANK_DATA  = 16'h8001;
  localparam logic [15:0] MMC3_MIRROR     = 16'hA000;
  localparam logic [15:0] MMC3_PRG_RAM    = 16'hA001;
  localparam logic [15:0] MMC3_IRQ_LATCH  = 16'hC000;
  localparam logic [15:0] MMC3_IRQ_RELOAD = 16'hC001;
  localparam logic [15:0] MMC3_IRQ_DIS    = 16'hE000;
  localparam logic [15:0] MMC3_IRQ_EN     = 16'hE001;

  // Idle bus cycle: a read of addr that no command asked for.
  function automatic bus_cyc_t idle_cyc(input logic [15:0] addr);
    bus_cyc_t c;
    c.write = 1'b0;
    c.addr  = addr;
    c.wdata = 8'h00;
    return c;
  endfunction

endpackage

// File: rtl/m2_phase_gen.sv
// M2 clock generator: a two-state FSM with a phase counter.
//   clk, rst_n  : system clock, async active-low reset
//   m2          : registered M2 output, LOW then HIGH for M2_DIV clk each
//   cycle_start : first clk of LOW (first clk of a bus cycle)
//   low_last    : last clk of LOW (next clk is the first HIGH clk)
//   cycle_last  : last clk of HIGH (last clk of a bus cycle)
module m2_phase_gen
  import nes_bus_pkg::*;
#(
  parameter int M2_DIV = 6
) (
  input  logic clk,
  input  logic rst_n,
  output logic m2,
  output logic cycle_start,
  output logic low_last,
  output logic cycle_last
);

  localparam logic [7:0] CNT_MAX = 8'(M2_DIV - 1);

  m2_state_t  state;
  logic [7:0] cnt;

  assign cycle_start = (state == ST_LOW)  && (cnt == 8'd0);
  assign low_last    = (state == ST_LOW)  && (cnt == CNT_MAX);
  assign cycle_last  = (state == ST_HIGH) && (cnt == CNT_MAX);

  // Reset parks the FSM at LOW/0, so the clk right after release is
  // already the first LOW clk of the first bus cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_LOW;
      cnt   <= 8'd0;
      m2    <= 1'b0;
    end else begin
      case (state)
        ST_LOW: begin
          if (cnt == CNT_MAX) begin
            state <= ST_HIGH;
            cnt   <= 8'd0;
            m2    <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_HIGH: begin
          if (cnt == CNT_MAX) begin
            state <= ST_LOW;
            cnt   <= 8'd0;
            m2    <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/nes_cpu_bus_master.sv
// NES CPU-side cartridge bus initiator for mapper bring-up.
//   cmd_*        : command in (valid/ready), one command per M2 period
//   rsp_*        : read response, one-clk rsp_valid pulse, rsp_rdata held
//   m2, romsel   : CPU M2 clock and /ROMSEL (~(A15 & m2))
//   cpu_rw       : 1 = read, 0 = write
//   cpu_addr     : A14..A0, stable for the whole bus cycle
//   cpu_data_*   : write data / drive enable (HIGH phase of writes) / read data
//   a12_en       : enables the PPU A12 pulse train on ppu_a12
//   irq_n        : async mapper /IRQ; irq_seen is sticky, irq_clr clears it
module nes_cpu_bus_master
  import nes_bus_pkg::*;
#(
  parameter int          M2_DIV     = 6,
  parameter int          A12_PERIOD = 114,
  parameter logic [15:0] IDLE_ADDR  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        m2,
  output logic        romsel,
  output logic        cpu_rw,
  output logic [14:0] cpu_addr,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_data_oe,
  input  logic [7:0]  cpu_data_in,
  input  logic        a12_en,
  output logic        ppu_a12,
  input  logic        irq_n,
  output logic        irq_seen,
  input  logic        irq_clr
);

  localparam logic [9:0] A12_MAX = 10'(A12_PERIOD - 1);

  logic     cycle_start, low_last, cycle_last;
  bus_cyc_t cur;
  logic     cur_rd_cmd;   // current cycle is a commanded read (not idle)

  m2_phase_gen #(.M2_DIV(M2_DIV)) u_phase (
    .clk         (clk),
    .rst_n       (rst_n),
    .m2          (m2),
    .cycle_start (cycle_start),
    .low_last    (low_last),
    .cycle_last  (cycle_last)
  );

  // Commands are taken only at the bus-cycle boundary so that address and
  // R/W never move inside a cycle.
  assign cmd_ready    = cycle_last;
  assign cpu_rw       = ~cur.write;
  assign cpu_addr     = cur.addr[14:0];
  assign cpu_data_out = cur.wdata;
  // Falls together with m2, which is the MMC3 write strobe for A15=1 writes.
  assign romsel       = ~(cur.addr[15] & m2);

  // Bus-cycle register and data drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur         <= idle_cyc(IDLE_ADDR);
      cur_rd_cmd  <= 1'b0;
      cpu_data_oe <= 1'b0;
    end else begin
      if (cycle_last) begin
        if (cmd_valid) begin
          cur.write  <= cmd_write;
          cur.addr   <= cmd_addr;
          cur.wdata  <= cmd_wdata;
          cur_rd_cmd <= ~cmd_write;
        end else begin
          cur        <= idle_cyc(IDLE_ADDR);
          cur_rd_cmd <= 1'b0;
        end
      end
      // Drive for the whole HIGH phase; release on the first LOW clk of
      // the next cycle, after the strobe edge.
      if (low_last)
        cpu_data_oe <= cur.write;
      else if (cycle_last)
        cpu_data_oe <= 1'b0;
    end
  end

  // Read capture: sample on the last HIGH clk, respond on the next clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
    end else begin
      if (cycle_last && cur_rd_cmd)
        rsp_rdata <= cpu_data_in;
      if (cycle_last)
        rsp_valid <= cur_rd_cmd;
      else if (cycle_start)
        rsp_valid <= 1'b0;
    end
  end

  // A12 generator: counts bus cycles; the pulse covers cycle 0 of each
  // period, from LOW start to LOW start, so it is updated at cycle_last.
  logic       a12_run;
  logic [9:0] a12_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a12_run <= 1'b0;
      a12_cnt <= 10'd0;
      ppu_a12 <= 1'b0;
    end else if (cycle_last) begin
      if (!a12_en) begin
        a12_run <= 1'b0;
        a12_cnt <= 10'd0;
        ppu_a12 <= 1'b0;
      end else if (!a12_run) begin
        a12_run <= 1'b1;
        a12_cnt <= 10'd0;
        ppu_a12 <= 1'b1;
      end else if (a12_cnt == A12_MAX) begin
        a12_cnt <= 10'd0;
        ppu_a12 <= 1'b1;
      end else begin
        a12_cnt <= a12_cnt + 10'd1;
        ppu_a12 <= 1'b0;
      end
    end
  end

  // /IRQ sampler: 2-flop synchronizer, sticky flag, set beats clear.
  logic [1:0] irq_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_sync <= 2'b11;
      irq_seen <= 1'b0;
    end else begin
      irq_sync <= {irq_sync[0], irq_n};
      if (!irq_sync[1])
        irq_seen <= 1'b1;
      else if (irq_clr)
        irq_seen <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nes_cpu_bus_master.sv
// Directed bench for nes_cpu_bus_master with M2_DIV=2, A12_PERIOD=4.
// Inputs change and outputs are sampled on the falling clk edge.
module tb_nes_cpu_bus_master;
  import nes_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [15:0] cmd_addr = 16'h0;
  logic [7:0]  cmd_wdata = 8'h0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        m2, romsel, cpu_rw, cpu_data_oe, ppu_a12, irq_seen;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic [7:0]  cpu_data_in = 8'h0;
  logic        a12_en = 1'b0, irq_n = 1'b1, irq_clr = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nes_cpu_bus_master #(.M2_DIV(2), .A12_PERIOD(4), .IDLE_ADDR(16'h0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .m2           (m2),
    .romsel       (romsel),
    .cpu_rw       (cpu_rw),
    .cpu_addr     (cpu_addr),
    .cpu_data_out (cpu_data_out),
    .cpu_data_oe  (cpu_data_oe),
    .cpu_data_in  (cpu_data_in),
    .a12_en       (a12_en),
    .ppu_a12      (ppu_a12),
    .irq_n        (irq_n),
    .irq_seen     (irq_seen),
    .irq_clr      (irq_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge that shows cmd_ready (bounded).
  task automatic wait_rdy();
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk("rdy_wait", cmd_ready, 1);
  endtask

  // Offer one command; returns just after the handshake edge (bus clk 0).
  task automatic issue(input logic w, input logic [15:0] a, input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    wait_rdy();
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Check the four clks of one bus cycle (M2_DIV=2).
  task automatic check_cycle(input string tag, input logic w, input logic [15:0] a,
                             input logic [7:0] d);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk({tag, "_m2"},     m2, (k >= 2));
      chk({tag, "_romsel"}, romsel, !(a[15] && k >= 2));
      chk({tag, "_rw"},     cpu_rw, !w);
      chk({tag, "_addr"},   cpu_addr, a[14:0]);
      chk({tag, "_oe"},     cpu_data_oe, (w && k >= 2));
      chk({tag, "_rdy"},    cmd_ready, (k == 3));
      if (w && k >= 2) chk({tag, "_data"}, cpu_data_out, d);
    end
  endtask

  initial begin
    int first_rsp;
    int n_rsp;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_m2", m2, 0);
    chk("rst_romsel", romsel, 1);
    chk("rst_rw", cpu_rw, 1);
    chk("rst_addr", cpu_addr, 0);
    chk("rst_dout", cpu_data_out, 0);
    chk("rst_oe", cpu_data_oe, 0);
    chk("rst_rdy", cmd_ready, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_a12", ppu_a12, 0);
    chk("rst_irq", irq_seen, 0);

    // Idle bus: clk 0 after release is LOW clk 0; first sample is clk 1.
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("idle_m2", m2, (((i + 1) % 4) >= 2));
      chk("idle_romsel", romsel, 1);
      chk("idle_rw", cpu_rw, 1);
      chk("idle_addr", cpu_addr, 0);
      chk("idle_rdy", cmd_ready, (((i + 1) % 4) == 3));
    end

    // Back-to-back MMC3 writes
    issue(1'b1, MMC3_BANK_SEL, 8'h06);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = MMC3_BANK_DATA;
    cmd_wdata = 8'h1F;
    check_cycle("w8000", 1'b1, MMC3_BANK_SEL, 8'h06);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check_cycle("w8001", 1'b1, MMC3_BANK_DATA, 8'h1F);
    @(negedge clk);
    chk("post_w_oe", cpu_data_oe, 0);
    chk("post_w_romsel", romsel, 1);
    chk("post_w_rw", cpu_rw, 1);
    chk("post_w_addr", cpu_addr, 0);

    // Read $FFFC
    cpu_data_in = 8'hA5;
    issue(1'b0, 16'hFFFC, 8'h00);
    first_rsp = 0;
    n_rsp = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) chk("rd_rw", cpu_rw, 1);
      if (n == 1) chk("rd_addr", cpu_addr, 15'h7FFC);
      if (n == 3) chk("rd_romsel", romsel, 0);
      if (n == 3) chk("rd_oe", cpu_data_oe, 0);
      if (rsp_valid) begin
        n_rsp++;
        if (first_rsp == 0) first_rsp = n;
      end
      if (n == 5) chk("rd_rdata", rsp_rdata, 8'hA5);
    end
    chk("rd_latency", first_rsp, 5);
    chk("rd_pulses", n_rsp, 1);
    cpu_data_in = 8'h3C;
    n_rsp = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (rsp_valid) n_rsp++;
    end
    chk("rd_idle_pulses", n_rsp, 0);
    chk("rd_hold", rsp_rdata, 8'hA5);

    // Write below $8000: no /ROMSEL
    issue(1'b1, 16'h6000, 8'h55);
    check_cycle("w6000", 1'b1, 16'h6000, 8'h55);

    // A12 pulse train, then disable mid-pulse
    wait_rdy();
    a12_en = 1'b1;
    for (int n = 0; n < 44; n++) begin
      @(negedge clk);
      chk("a12", ppu_a12, (n < 36) ? (((n / 4) % 4) == 0) : 1'b0);
      if (n == 33) a12_en = 1'b0;
    end

    // IRQ: one-clk low pulse, clear coincident with set, then clear alone
    irq_n = 1'b0;
    @(negedge clk);
    irq_n = 1'b1;
    @(negedge clk);
    chk("irq_pre", irq_seen, 0);
    irq_clr = 1'b1;
    @(negedge clk);
    chk("irq_set", irq_seen, 1);
    irq_clr = 1'b0;
    @(negedge clk);
    chk("irq_sticky", irq_seen, 1);
    irq_clr = 1'b1;
    @(negedge clk);
    chk("irq_clr", irq_seen, 0);
    irq_clr = 1'b0;
    @(negedge clk);
    chk("irq_stay_clr", irq_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
